// File: rtl/fixed_point_params.vh
// Shared fixed-point format for the qubit datapath: signed S4.4 amplitudes, 1.0 = 16.
`ifndef FIXED_POINT_PARAMS_VH
`define FIXED_POINT_PARAMS_VH
`define TOTAL_WIDTH 8
`define FRAC_WIDTH 4
`endif

// File: rtl/cphase_gate_pipelined.sv
// Three-stage controlled-phase gate: rotates the |1> amplitude by a selectable
// phase (pi, pi/2, pi/4, pi/8) when ctrl=1, passes the |0> amplitude through delay-matched.
`include "fixed_point_params.vh"

module cphase_gate_pipelined #(
    parameter int SATURATE = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            in_valid,
    input  logic                            ctrl,
    input  logic [1:0]                      phase_sel,
    input  logic signed [`TOTAL_WIDTH-1:0]  alpha_r,
    input  logic signed [`TOTAL_WIDTH-1:0]  alpha_i,
    input  logic signed [`TOTAL_WIDTH-1:0]  beta_r,
    input  logic signed [`TOTAL_WIDTH-1:0]  beta_i,
    output logic                            out_valid,
    output logic signed [`TOTAL_WIDTH-1:0]  new_alpha_r,
    output logic signed [`TOTAL_WIDTH-1:0]  new_alpha_i,
    output logic signed [`TOTAL_WIDTH-1:0]  new_beta_r,
    output logic signed [`TOTAL_WIDTH-1:0]  new_beta_i
);

    localparam int unsigned W  = `TOTAL_WIDTH;
    localparam int unsigned F  = `FRAC_WIDTH;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned SW = 2 * W + 1;
    localparam int          MAX_I = (1 <<< (W - 1)) - 1;
    localparam int          MIN_I = -(1 <<< (W - 1));
    localparam logic signed [SW-1:0] MAX_V = SW'(MAX_I);
    localparam logic signed [SW-1:0] MIN_V = SW'(MIN_I);

    // Stage 1 registers
    logic                  v1;
    logic signed [W-1:0]   a_r1, a_i1, b_r1, b_i1, c1, s1;
    // Stage 2 registers
    logic                  v2;
    logic signed [W-1:0]   a_r2, a_i2;
    logic signed [PW-1:0]  p_rc, p_is, p_rs, p_ic;

    logic signed [W-1:0]   c_sel, s_sel;
    logic signed [SW-1:0]  re_full, im_full, re_sh, im_sh;

    // Phase table; ctrl=0 selects the identity rotation (1.0, 0).
    always_comb begin
        c_sel = W'(16);
        s_sel = W'(0);
        if (ctrl) begin
            case (phase_sel)
                2'd0:    begin c_sel = W'(-16); s_sel = W'(0);  end
                2'd1:    begin c_sel = W'(0);   s_sel = W'(16); end
                2'd2:    begin c_sel = W'(11);  s_sel = W'(11); end
                default: begin c_sel = W'(15);  s_sel = W'(6);  end
            endcase
        end
    end

    // Complex combine at full precision, then floor-shift back to S4.4.
    always_comb begin
        re_full = SW'(p_rc) - SW'(p_is);
        im_full = SW'(p_rs) + SW'(p_ic);
        re_sh   = re_full >>> F;
        im_sh   = im_full >>> F;
    end

    function automatic logic signed [W-1:0] fit(input logic signed [SW-1:0] v);
        logic signed [W-1:0] r;
        r = W'(v);
        if (SATURATE != 0) begin
            if (v > MAX_V)      r = W'(MAX_I);
            else if (v < MIN_V) r = W'(MIN_I);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1          <= 1'b0;
            a_r1        <= '0;
            a_i1        <= '0;
            b_r1        <= '0;
            b_i1        <= '0;
            c1          <= '0;
            s1          <= '0;
            v2          <= 1'b0;
            a_r2        <= '0;
            a_i2        <= '0;
            p_rc        <= '0;
            p_is        <= '0;
            p_rs        <= '0;
            p_ic        <= '0;
            out_valid   <= 1'b0;
            new_alpha_r <= '0;
            new_alpha_i <= '0;
            new_beta_r  <= '0;
            new_beta_i  <= '0;
        end else if (en) begin
            v1          <= in_valid;
            a_r1        <= alpha_r;
            a_i1        <= alpha_i;
            b_r1        <= beta_r;
            b_i1        <= beta_i;
            c1          <= c_sel;
            s1          <= s_sel;

            v2          <= v1;
            a_r2        <= a_r1;
            a_i2        <= a_i1;
            p_rc        <= b_r1 * c1;
            p_is        <= b_i1 * s1;
            p_rs        <= b_r1 * s1;
            p_ic        <= b_i1 * c1;

            out_valid   <= v2;
            new_alpha_r <= a_r2;
            new_alpha_i <= a_i2;
            new_beta_r  <= fit(re_sh);
            new_beta_i  <= fit(im_sh);
        end
    end

endmodule

// File: tb/tb_cphase_gate_pipelined.sv
// Directed bench for cphase_gate_pipelined: saturating and wrapping instances
// side by side, checked every cycle against a 3-deep expected-value pipeline.
module tb_cphase_gate_pipelined;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, en, in_valid, ctrl;
    logic [1:0]           phase_sel;
    logic signed [W-1:0]  alpha_r, alpha_i, beta_r, beta_i;

    logic                 out_valid, out_valid_w;
    logic signed [W-1:0]  na_r, na_i, nb_r, nb_i;
    logic signed [W-1:0]  na_r_w, na_i_w, nb_r_w, nb_i_w;

    cphase_gate_pipelined #(.SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .ctrl(ctrl),
        .phase_sel(phase_sel), .alpha_r(alpha_r), .alpha_i(alpha_i),
        .beta_r(beta_r), .beta_i(beta_i), .out_valid(out_valid),
        .new_alpha_r(na_r), .new_alpha_i(na_i), .new_beta_r(nb_r), .new_beta_i(nb_i)
    );

    cphase_gate_pipelined #(.SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .ctrl(ctrl),
        .phase_sel(phase_sel), .alpha_r(alpha_r), .alpha_i(alpha_i),
        .beta_r(beta_r), .beta_i(beta_i), .out_valid(out_valid_w),
        .new_alpha_r(na_r_w), .new_alpha_i(na_i_w), .new_beta_r(nb_r_w), .new_beta_i(nb_i_w)
    );

    typedef struct {
        logic                ctrl;
        logic [1:0]          sel;
        logic signed [W-1:0] ar, ai, br, bi;
        logic signed [W-1:0] er, ei;   // saturating result
        logic signed [W-1:0] wr, wi;   // wrapping result
    } vec_t;

    typedef struct {
        logic                v;
        logic signed [W-1:0] ar, ai, er, ei, wr, wi;
    } exp_t;

    vec_t vecs[10];
    exp_t pipe[3];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic c, input int sel, input int ar, input int ai,
                                input int br, input int bi, input int er, input int ei,
                                input int wr, input int wi);
        vec_t v;
        v.ctrl = c;     v.sel = 2'(sel);
        v.ar = W'(ar);  v.ai = W'(ai);  v.br = W'(br);  v.bi = W'(bi);
        v.er = W'(er);  v.ei = W'(ei);  v.wr = W'(wr);  v.wi = W'(wi);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic set_in(input vec_t v, input logic vld);
        in_valid  = vld;
        ctrl      = v.ctrl;
        phase_sel = v.sel;
        alpha_r   = v.ar;  alpha_i = v.ai;
        beta_r    = v.br;  beta_i  = v.bi;
        cur.v  = vld;
        cur.ar = v.ar;  cur.ai = v.ai;
        cur.er = v.er;  cur.ei = v.ei;
        cur.wr = v.wr;  cur.wi = v.wi;
    endtask

    task automatic clear_pipe();
        for (int k = 0; k < 3; k++) pipe[k].v = 1'b0;
    endtask

    // One clock: advance the expected pipeline if enabled, then compare.
    task automatic step();
        @(posedge clk);
        if (en) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = cur;
        end
        #1;
        chk("out_valid", int'(out_valid), int'(pipe[2].v));
        chk("out_valid_wrap", int'(out_valid_w), int'(pipe[2].v));
        if (pipe[2].v) begin
            chk("alpha_r", int'(na_r), int'(pipe[2].ar));
            chk("alpha_i", int'(na_i), int'(pipe[2].ai));
            chk("beta_r_sat", int'(nb_r), int'(pipe[2].er));
            chk("beta_i_sat", int'(nb_i), int'(pipe[2].ei));
            chk("alpha_r_wrap", int'(na_r_w), int'(pipe[2].ar));
            chk("beta_r_wrap", int'(nb_r_w), int'(pipe[2].wr));
            chk("beta_i_wrap", int'(nb_i_w), int'(pipe[2].wi));
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, int'(out_valid) + int'(out_valid_w), 0);
        chk({name, "_data"}, int'(na_r) | int'(na_i) | int'(nb_r) | int'(nb_i), 0);
        chk({name, "_data_wrap"}, int'(na_r_w) | int'(na_i_w) | int'(nb_r_w) | int'(nb_i_w), 0);
    endtask

    initial begin
        logic signed [W-1:0] hold_r, hold_i;
        logic                hold_v;
        vec_t                x;

        //           ctrl sel  ar   ai    br    bi    er    ei    wr    wi
        vecs[0] = mk(1, 2,  11,  -5,   16,    0,   11,   11,   11,   11);
        vecs[1] = mk(1, 1,   3,   4,   16,   16,  -16,   16,  -16,   16);
        vecs[2] = mk(1, 2,  -7,   2,   -1,    0,   -1,   -1,   -1,   -1);
        vecs[3] = mk(1, 0,   1,  -1, -128,    0,  127,    0, -128,    0);
        vecs[4] = mk(0, 3,  20, -20,    7,   -3,    7,   -3,    7,   -3);
        vecs[5] = mk(1, 3, -16,  16,    7,   -3,    7,   -1,    7,   -1);
        vecs[6] = mk(1, 0, 127,-128,    5,   -7,   -5,    7,   -5,    7);
        vecs[7] = mk(1, 1,   0,   0, -128, -128,  127, -128, -128, -128);
        vecs[8] = mk(1, 1,  -1,   1,  127,  127, -127,  127, -127,  127);
        vecs[9] = mk(1, 3,   9,   8, -128,  127, -128,   71,   88,   71);

        rst_n = 1'b1;
        en    = 1'b0;
        set_in(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        clear_pipe();
        #1 rst_n = 1'b0;
        #1 chk_zero("reset_initial");
        #10 rst_n = 1'b1;
        en = 1'b1;

        // Back-to-back stream of the table, then flush.
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i], 1'b1);
            step();
        end
        set_in(vecs[0], 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Per-sample control: alternate ctrl with fixed beta and sel=3.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) x = mk(0, 3, i, -i, 7, -3, 7, -3, 7, -3);
            else            x = mk(1, 3, i, -i, 7, -3, 7, -1, 7, -1);
            set_in(x, 1'b1);
            step();
        end
        set_in(vecs[0], 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Stall: two samples, en low four cycles with junk inputs, then the third.
        set_in(vecs[0], 1'b1); step();
        set_in(vecs[7], 1'b1); step();
        en = 1'b0;
        hold_v = out_valid;
        hold_r = nb_r;
        hold_i = na_r;
        set_in(vecs[9], 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_hold_valid", int'(out_valid), int'(hold_v));
            chk("stall_hold_beta_r", int'(nb_r), int'(hold_r));
            chk("stall_hold_alpha_r", int'(na_r), int'(hold_i));
        end
        en = 1'b1;
        set_in(vecs[3], 1'b1); step();
        set_in(vecs[3], 1'b0);
        for (int i = 0; i < 4; i++) step();

        // Asynchronous reset with three samples in flight.
        set_in(vecs[1], 1'b1); step();
        set_in(vecs[5], 1'b1); step();
        set_in(vecs[9], 1'b1); step();
        #3 rst_n = 1'b0;
        #1 chk_zero("reset_async");
        clear_pipe();
        @(posedge clk);
        #1 chk_zero("reset_held");
        rst_n = 1'b1;
        set_in(vecs[2], 1'b0);
        for (int i = 0; i < 4; i++) step();
        set_in(vecs[6], 1'b1); step();
        set_in(vecs[6], 1'b0);
        for (int i = 0; i < 3; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
